// File: rtl/riscv_gpio_pkg.sv
// Shared constants for the RISC-V GPIO peripheral: bus width and register offsets.
package riscv_gpio_pkg;

  localparam int BUS_W = 32;

  localparam logic [3:0] GPIO_OUT_OFS   = 4'h0;
  localparam logic [3:0] GPIO_IN_OFS    = 4'h4;
  localparam logic [3:0] GPIO_EDGE_OFS  = 4'h8;
  localparam logic [3:0] GPIO_IRQEN_OFS = 4'hC;

endpackage

// File: rtl/riscv_gpio_if.sv
// Core data-bus slice seen by the GPIO peripheral: single-cycle select with a one-cycle read strobe.
interface riscv_gpio_if;
  import riscv_gpio_pkg::*;

  logic             bus_sel;
  logic             bus_we;
  logic [3:0]       bus_addr;
  logic [BUS_W-1:0] bus_wdata;
  logic [BUS_W-1:0] bus_rdata;
  logic             bus_rvalid;

  modport master (
    output bus_sel, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_rvalid
  );

  modport slave (
    input  bus_sel, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_rvalid
  );

endinterface

// File: rtl/riscv_gpio_port_debounce.sv
// Pin input conditioning: 2-flop synchroniser, periodic sample tick and a two-sample agreement filter.
module gpio_debounce #(
  parameter int W       = 32,
  parameter int DEB_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] pin_in,
  output logic [W-1:0] deb_out,
  output logic [W-1:0] rise_out
);

  localparam int            CW       = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_DIV - 1);

  logic [W-1:0]  sync1_q, sync1_d;
  logic [W-1:0]  sync2_q, sync2_d;
  logic [W-1:0]  samp_q, samp_d;
  logic [W-1:0]  deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  logic [W-1:0]  agree;

  always_comb begin
    sync1_d = pin_in;
    sync2_d = sync1_q;
    tick    = (cnt_q == CNT_LAST);
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    agree   = ~(sync2_q ^ samp_q);
    samp_d  = tick ? sync2_q : samp_q;
    // A bit only moves once the new sample matches the previous one.
    deb_d   = tick ? ((agree & sync2_q) | (~agree & deb_q)) : deb_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      samp_q  <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      samp_q  <= samp_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_out  = deb_q;
  // Rise is taken from the next-state value so EDGE latches on the same edge IN changes.
  assign rise_out = deb_d & ~deb_q;

endmodule

// File: rtl/riscv_gpio_port.sv
// Memory-mapped GPIO: output register, debounced input, sticky W1C rising-edge status and level IRQ.
module riscv_gpio_port
  import riscv_gpio_pkg::*;
#(
  parameter int               IN_W      = 32,
  parameter int               OUT_W     = 8,
  parameter int               DEB_DIV   = 4,
  parameter logic [OUT_W-1:0] OUT_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  riscv_gpio_if.slave      bus,
  input  logic [IN_W-1:0]  gpio_port_in,
  output logic [OUT_W-1:0] gpio_port_out,
  output logic             irq
);

  logic [OUT_W-1:0] out_q, out_d;
  logic [IN_W-1:0]  edge_q, edge_d;
  logic [IN_W-1:0]  irqen_q, irqen_d;
  logic [BUS_W-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic [IN_W-1:0]  in_deb;
  logic [IN_W-1:0]  in_rise;
  logic [IN_W-1:0]  edge_clr;
  logic [BUS_W-1:0] rd_mux;
  logic [3:0]       word_addr;
  logic             wr_en, rd_en;
  logic             unused_addr_lsb;

  gpio_debounce #(
    .W       (IN_W),
    .DEB_DIV (DEB_DIV)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .pin_in   (gpio_port_in),
    .deb_out  (in_deb),
    .rise_out (in_rise)
  );

  always_comb begin
    wr_en     = bus.bus_sel & bus.bus_we;
    rd_en     = bus.bus_sel & ~bus.bus_we;
    word_addr = {bus.bus_addr[3:2], 2'b00};

    out_d    = out_q;
    irqen_d  = irqen_q;
    edge_clr = '0;
    if (wr_en) begin
      case (word_addr)
        GPIO_OUT_OFS:   out_d    = bus.bus_wdata[OUT_W-1:0];
        GPIO_EDGE_OFS:  edge_clr = bus.bus_wdata[IN_W-1:0];
        GPIO_IRQEN_OFS: irqen_d  = bus.bus_wdata[IN_W-1:0];
        default: ;
      endcase
    end
    // A rise on the same edge as a clear must not be lost.
    edge_d = (edge_q & ~edge_clr) | in_rise;

    rd_mux = '0;
    case (word_addr)
      GPIO_OUT_OFS:   rd_mux[OUT_W-1:0] = out_q;
      GPIO_IN_OFS:    rd_mux[IN_W-1:0]  = in_deb;
      GPIO_EDGE_OFS:  rd_mux[IN_W-1:0]  = edge_q;
      GPIO_IRQEN_OFS: rd_mux[IN_W-1:0]  = irqen_q;
      default:        rd_mux            = '0;
    endcase
    rdata_d  = rd_en ? rd_mux : rdata_q;
    rvalid_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q    <= OUT_RESET;
      edge_q   <= '0;
      irqen_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      edge_q   <= edge_d;
      irqen_q  <= irqen_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.bus_rdata  = rdata_q;
  assign bus.bus_rvalid = rvalid_q;
  assign gpio_port_out  = out_q;
  assign irq            = |(edge_q & irqen_q);

  assign unused_addr_lsb = ^bus.bus_addr[1:0];

endmodule
